uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, serial data bits per frame (5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, TX holding FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter PRESCALE_W, default 8, width of the per-bit clock-count input.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-007 Data_Valid  input  1  write strobe; one word per high cycle.
REQ-008 parity_enable  input  1  1 = insert parity bit after data.
REQ-009 parity_type  input  1  0 = even, 1 = odd.
REQ-010 stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
REQ-011 prescale  input  PRESCALE_W  clock cycles per serial bit; 0 treated as 1.
REQ-012 TX_OUT  output  1  registered serial line, idle high.
REQ-013 busy  output  1  high while a frame is on the line.
REQ-014 fifo_full  output  1  FIFO holds FIFO_DEPTH words.
REQ-015 fifo_empty  output  1  FIFO holds no words.

Function
REQ-016 Frame SHALL be: start (0), DATA_WIDTH data bits LSB first, parity bit if enabled, 1 or 2 stop bits (1).
REQ-017 Each bit SHALL last exactly max(prescale,1) clk cycles, counted by an internal down-counter.
REQ-018 FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY skipped when parity disabled; STOP repeated once when stop_bits=1.
REQ-019 Write SHALL be accepted on a cycle with Data_Valid=1 and fifo_full=0; otherwise the word is dropped with no other state change.
REQ-020 fifo_full SHALL be evaluated before a same-cycle pop; write when full is dropped even if a pop occurs that cycle.
REQ-021 Simultaneous write and pop when not full SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-022 In IDLE with FIFO non-empty, FSM SHALL pop the head word and enter START on the same edge; TX_OUT falls on the 2nd rising edge after the accepting write edge.
REQ-023 prescale, parity_enable, parity_type, stop_bits and the data word SHALL be latched at pop and held constant for that frame.
REQ-024 Parity SHALL be XOR of latched data, inverted when parity_type=1.
REQ-025 After the final stop-bit cycle, FSM SHALL pop the next word with no idle gap if FIFO non-empty, else return to IDLE.
REQ-026 busy SHALL be 1 in every non-IDLE state and 0 in IDLE.

Reset
REQ-027 rst_n low SHALL asynchronously force TX_OUT=1, busy=0, fifo_empty=1, fifo_full=0, FSM=IDLE, pointers and counters=0.
REQ-028 Reset mid-frame SHALL abort the frame and discard FIFO contents; first frame after release follows REQ-022.

Configuration
REQ-029 With macro UART_TX_OVERFLOW_EN defined, SHALL add output overflow (1 bit, sticky, set on a dropped write) and input overflow_clr (1 bit, clears it; set wins over same-cycle clear); reset value 0.
REQ-030 Without UART_TX_OVERFLOW_EN, neither port SHALL exist and dropped writes SHALL be silent.

Verification
REQ-031 prescale=4, parity off, 1 stop, write 0xA5 -> TX_OUT 0,1,0,1,0,0,1,0,1,1 each 4 cycles; busy high 40 cycles.
REQ-032 prescale=2, parity on even, 2 stop, write 0x07 -> parity bit 1, two stop bits, frame 24 cycles.
REQ-033 prescale=1, write 0x01,0x02,0x03 back-to-back -> three contiguous 10-cycle frames, no idle bit between.
REQ-034 FIFO_DEPTH=4, prescale=8, write 6 words in 6 cycles -> words 1-5 sent (1 popped, 4 queued), word 6 dropped; overflow=1 if UART_TX_OVERFLOW_EN.
REQ-035 rst_n low at data bit 3 of a frame with 2 words queued -> TX_OUT=1 immediately, fifo_empty=1, no frame after release until new write.
REQ-036 prescale=0, parity odd, write 0x00 -> 1-cycle bits, parity bit 1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small holding FIFO; frames are start, data LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_OVERFLOW_EN to add the sticky overflow flag and its clear input.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic                  stop_bits,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  fifo_full,
    output logic                  fifo_empty
`ifdef UART_TX_OVERFLOW_EN
    ,
    output logic                  overflow,
    input  logic                  overflow_clr
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [BW-1:0] BIT_ONE = BW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] PS_ONE = PRESCALE_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_en;
    logic                  pop;

    logic [DATA_WIDTH-1:0] data_q;
    logic [PRESCALE_W-1:0] ps_q;
    logic [PRESCALE_W-1:0] cnt;
    logic [PRESCALE_W-1:0] ps_eff;
    logic                  par_en_q;
    logic                  par_odd_q;
    logic                  stop2_q;
    logic [BW-1:0]         bit_idx;
    logic                  stop_idx;
    logic                  tick;
    logic                  line_bit;

    // full is taken from the registered count, so a same-cycle pop never frees room
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign wr_en      = Data_Valid && !fifo_full;
    assign busy       = (state != IDLE);
    assign tick       = busy && (cnt == '0);
    assign ps_eff     = (prescale == '0) ? PS_ONE : prescale;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= P_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (tick) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (tick && (bit_idx == LAST_BIT)) begin
                    state_nx = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (tick && (!stop2_q || stop_idx)) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        line_bit = 1'b1;
        unique case (state)
            START:   line_bit = 1'b0;
            DATA:    line_bit = data_q[bit_idx];
            PARITY:  line_bit = (^data_q) ^ par_odd_q;
            default: line_bit = 1'b1;
        endcase
    end

    // frame settings are captured at pop so input changes never disturb a frame in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            TX_OUT    <= 1'b1;
            data_q    <= '0;
            ps_q      <= '0;
            cnt       <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
        end else begin
            state  <= state_nx;
            TX_OUT <= line_bit;
            if (pop) begin
                data_q    <= mem[rd_ptr];
                ps_q      <= ps_eff;
                cnt       <= ps_eff - PS_ONE;
                par_en_q  <= parity_enable;
                par_odd_q <= parity_type;
                stop2_q   <= stop_bits;
                bit_idx   <= '0;
                stop_idx  <= 1'b0;
            end else if (tick) begin
                cnt <= ps_q - PS_ONE;
                if (state == DATA) begin
                    bit_idx <= bit_idx + BIT_ONE;
                end
                if (state == STOP) begin
                    stop_idx <= 1'b1;
                end
            end else if (busy) begin
                cnt <= cnt - PS_ONE;
            end
        end
    end

`ifdef UART_TX_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (Data_Valid && fifo_full) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted words queue expected frames,
// a line monitor decodes TX_OUT cycle by cycle and compares against them.
module tb_uart_tx_fifo;

    localparam int DW = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          parity_enable = 1'b0;
    logic          parity_type = 1'b0;
    logic          stop_bits = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic          TX_OUT;
    logic          busy;
    logic          fifo_full;
    logic          fifo_empty;
`ifdef UART_TX_OVERFLOW_EN
    logic          overflow;
    logic          overflow_clr = 1'b0;
`endif

    uart_tx_fifo #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(4),
        .PRESCALE_W(PW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .P_DATA(P_DATA),
        .Data_Valid(Data_Valid),
        .parity_enable(parity_enable),
        .parity_type(parity_type),
        .stop_bits(stop_bits),
        .prescale(prescale),
        .TX_OUT(TX_OUT),
        .busy(busy),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty)
`ifdef UART_TX_OVERFLOW_EN
        ,
        .overflow(overflow),
        .overflow_clr(overflow_clr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            p;
        bit            pen;
        bit            podd;
        bit            s2;
    } exp_t;

    exp_t exp_q[$];
    int   start_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_total = 0;
    int   wr_cyc = 0;

    bit   m_active = 1'b0;
    int   m_idx = 0;
    int   m_cyc = 0;
    int   m_p = 1;
    int   m_nbits = 0;
    bit   m_bits[16];
    exp_t m_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) busy_total = busy_total + 1;
        if (!rst_n) begin
            m_active = 1'b0;
            exp_q.delete();
        end else if (!m_active && TX_OUT === 1'b0) begin
            start_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 1, 0);
            end else begin
                m_e = exp_q.pop_front();
                m_p = m_e.p;
                m_nbits = 0;
                m_bits[m_nbits] = 1'b0;
                m_nbits++;
                for (int i = 0; i < DW; i++) begin
                    m_bits[m_nbits] = m_e.data[i];
                    m_nbits++;
                end
                if (m_e.pen) begin
                    m_bits[m_nbits] = (^m_e.data) ^ m_e.podd;
                    m_nbits++;
                end
                m_bits[m_nbits] = 1'b1;
                m_nbits++;
                if (m_e.s2) begin
                    m_bits[m_nbits] = 1'b1;
                    m_nbits++;
                end
                m_active = 1'b1;
                m_idx = 0;
                m_cyc = 0;
            end
        end
        if (m_active) begin
            check($sformatf("line_bit%0d", m_idx), TX_OUT, m_bits[m_idx]);
            m_cyc++;
            if (m_cyc == m_p) begin
                m_cyc = 0;
                m_idx++;
                if (m_idx == m_nbits) m_active = 1'b0;
            end
        end
    end

    task automatic cfg(input int p, input bit pen, input bit podd, input bit s2);
        prescale = PW'(p);
        parity_enable = pen;
        parity_type = podd;
        stop_bits = s2;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit accept);
        exp_t e;
        P_DATA = d;
        Data_Valid = 1'b1;
        if (accept) begin
            e.data = d;
            e.p = (prescale == '0) ? 1 : int'(prescale);
            e.pen = parity_enable;
            e.podd = parity_type;
            e.s2 = stop_bits;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        wr_cyc = cyc;
        Data_Valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !fifo_empty || m_active) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", n < 3000, 1);
        check("scoreboard_drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b0;
        int s0;
        int n;
        int p;
        int k;
        bit pen;
        bit s2;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", TX_OUT, 1);
        check("rst_busy", busy, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
`ifdef UART_TX_OVERFLOW_EN
        check("rst_ovf", overflow, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        cfg(4, 0, 0, 0);
        b0 = busy_total;
        send(8'hA5, 1);
        check("a5_empty_after_wr", fifo_empty, 0);
        wait_idle();
        check("a5_latency", start_q[start_q.size()-1] - wr_cyc, 2);
        check("a5_busy_cycles", busy_total - b0, 40);

        cfg(2, 1, 0, 1);
        b0 = busy_total;
        send(8'h07, 1);
        wait_idle();
        check("p07_busy_cycles", busy_total - b0, 24);

        cfg(0, 1, 1, 0);
        b0 = busy_total;
        send(8'h00, 1);
        wait_idle();
        check("ps0_busy_cycles", busy_total - b0, 11);

        cfg(1, 0, 0, 0);
        b0 = busy_total;
        s0 = start_q.size();
        send(8'h01, 1);
        send(8'h02, 1);
        send(8'h03, 1);
        wait_idle();
        check("b2b_frames", start_q.size() - s0, 3);
        if (start_q.size() - s0 >= 3) begin
            check("b2b_gap1", start_q[s0+1] - start_q[s0], 10);
            check("b2b_gap2", start_q[s0+2] - start_q[s0+1], 10);
        end
        check("b2b_busy_cycles", busy_total - b0, 30);

        cfg(8, 0, 0, 0);
        s0 = start_q.size();
        for (int i = 1; i <= 6; i++) begin
            send(DW'(8'h10 + i), i <= 5);
        end
        check("ovf_full", fifo_full, 1);
        check("ovf_not_empty", fifo_empty, 0);
`ifdef UART_TX_OVERFLOW_EN
        check("ovf_flag", overflow, 1);
        overflow_clr = 1'b1;
        @(posedge clk);
        #1;
        overflow_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
`endif
        wait_idle();
        check("ovf_frames", start_q.size() - s0, 5);

        cfg(4, 0, 0, 0);
        send(8'hC3, 1);
        send(8'h5A, 1);
        send(8'h3C, 1);
        check("rst_mid_queued", fifo_empty, 0);
        n = 0;
        while (!(m_active && m_idx == 4) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reach_data_bit3", n < 200, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", TX_OUT, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_empty", fifo_empty, 1);
        check("rst_mid_full", fifo_full, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s0 = start_q.size();
        repeat (60) @(posedge clk);
        #1;
        check("no_frame_after_rst", start_q.size() - s0, 0);
        check("idle_after_rst", busy, 0);
        send(8'h96, 1);
        wait_idle();
        check("post_rst_latency", start_q[start_q.size()-1] - wr_cyc, 2);

        for (int r = 0; r < 8; r++) begin
            p = $urandom_range(0, 5);
            pen = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            cfg(p, pen, 1'($urandom_range(0, 1)), s2);
            k = $urandom_range(1, 3);
            b0 = busy_total;
            for (int j = 0; j < k; j++) begin
                send(DW'($urandom), 1);
            end
            wait_idle();
            check($sformatf("rand%0d_busy", r), busy_total - b0,
                  k * ((p == 0) ? 1 : p) * (10 + int'(pen) + int'(s2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
